// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment scanner: one shared segment bus, one-hot anodes,
// frame-synchronous display update, leading-zero blanking and anode dead time.

// Per-digit decode plus the leading-zero chain link for that digit.
module seg7_lane #(
  parameter int LANE = 0
) (
  input  logic [3:0] digit,
  input  logic       upper_zero,
  input  logic       blank_en,
  output logic       zero_here,
  output logic [6:0] seg
);
  always_comb begin
    zero_here = upper_zero && (digit == 4'd0);
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    // The least significant digit always shows, so "0" is never blank.
    if (blank_en && (LANE != 0) && zero_here) seg = 7'h00;
  end
endmodule

module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 2500,
  parameter int DEAD_CYCLES    = 1,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_AN  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                segments,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_done
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  // Inactive output levels; XOR with these maps active-high internals to pins.
  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

  logic [PW-1:0]                    presc;
  logic [IW-1:0]                    idx;
  logic [NUM_DIGITS-1:0][3:0]       pend_val, disp_val;
  logic [NUM_DIGITS-1:0]            pend_dp, disp_dp;
  logic                             slot_end, frame_end, lit;
  logic [NUM_DIGITS-1:0]            onehot;
  logic [NUM_DIGITS:0]              zero_chain;
  logic [NUM_DIGITS-1:0][6:0]       lane_seg;

  assign slot_end  = enable && (int'(presc) == REFRESH_DIV - 1);
  assign frame_end = slot_end && (int'(idx) == NUM_DIGITS - 1);
  assign lit       = enable && (int'(presc) >= DEAD_CYCLES);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
      end
      if (slot_end) begin
        presc <= '0;
        idx   <= frame_end ? '0 : idx + 1'b1;
      end else if (enable) begin
        presc <= presc + 1'b1;
      end
      // A load on the boundary edge bypasses pending so it lands in this frame.
      if (frame_end) begin
        disp_val <= load ? value_in : pend_val;
        disp_dp  <= load ? dp_in    : pend_dp;
      end
    end
  end

  assign zero_chain[NUM_DIGITS] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg7_lane #(.LANE(g)) u_lane (
      .digit      (disp_val[g]),
      .upper_zero (zero_chain[g+1]),
      .blank_en   (blank_lz),
      .zero_here  (zero_chain[g]),
      .seg        (lane_seg[g])
    );
  end

  // Segments and dp are forced off whenever no anode is driven (dead time,
  // disabled) so the bus never ghosts into the neighbouring digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode      <= AN_OFF;
      segments   <= SEG_OFF;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (lit) begin
        anode    <= onehot ^ AN_OFF;
        segments <= lane_seg[idx] ^ SEG_OFF;
        dp       <= disp_dp[idx] ^ DP_OFF;
      end else begin
        anode    <= AN_OFF;
        segments <= SEG_OFF;
        dp       <= DP_OFF;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: cycle scoreboard on an active-high and an active-low
// instance, table-driven frame checks, and hand sequences for timing corners.
module tb_seg7_scan_mux;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int DC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  segments, seg_n;
  logic        dp, dp_n, frame_done, fd_n;
  logic [3:0]  anode, an_n;

  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
                  .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .segments(segments), .dp(dp),
    .anode(anode), .frame_done(frame_done));

  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
                  .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) dut_n (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .segments(seg_n), .dp(dp_n),
    .anode(an_n), .frame_done(fd_n));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic            blz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  int          n_cmp = 0, n_bad = 0;
  int          m_presc = 0, m_idx = 0;
  logic [15:0] m_pv = '0, m_dv = '0;
  logic [3:0]  m_pd = '0, m_dd = '0;
  obs_t        exp_q[$];
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  // Blank every digit above the highest nonzero one.
  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int k, input logic blz);
    int h = 0;
    for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'd0) h = i;
    if (blz && k > h) return 7'h00;
    return ref_dec(v[4*k +: 4]);
  endfunction

  // One clock: predict outputs from pre-edge model state, queue them, advance the
  // model, then pop and compare once the DUT has registered its outputs.
  task automatic step();
    obs_t e;
    bit   b, lt;
    b     = enable && (m_presc == RD - 1);
    lt    = enable && (m_presc >= DC);
    e.fd  = b && (m_idx == N - 1);
    e.an  = lt ? 4'(1 << m_idx) : 4'h0;
    e.seg = lt ? ref_seg(m_dv, m_idx, blank_lz) : 7'h00;
    e.dp  = lt ? m_dd[m_idx] : 1'b0;
    if (reset) begin
      e = '0;
      m_presc = 0; m_idx = 0; m_pv = '0; m_dv = '0; m_pd = '0; m_dd = '0;
    end else begin
      if (e.fd) begin
        m_dv = load ? value_in : m_pv;
        m_dd = load ? dp_in : m_pd;
      end
      if (load) begin
        m_pv = value_in;
        m_pd = dp_in;
      end
      if (b) begin
        m_presc = 0;
        m_idx   = (m_idx + 1) % N;
      end else if (enable) begin
        m_presc++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("outputs", 32'({anode, segments, dp, frame_done}), 32'(e));
    chk("outputs_n", 32'({an_n, seg_n, dp_n, fd_n}),
        32'({e.an ^ 4'hF, e.seg ^ 7'h7F, ~e.dp, e.fd}));
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 40 && !frame_done; i++) step();
    chk("fd_seen", 32'(frame_done), 32'd1);
  endtask

  // Load a vector, wait for it to reach the display, check one whole frame.
  task automatic run_vec(input vec_t v);
    int lit_cnt = 0;
    value_in = v.val; dp_in = v.dpv; blank_lz = v.blz; load = 1'b1;
    step();
    load = 1'b0;
    wait_fd();
    for (int j = 0; j < 4 * RD; j++) begin
      step();
      for (int k = 0; k < N; k++)
        if (anode == 4'(1 << k)) begin
          chk("vec_seg", 32'(segments), 32'(v.seg[k]));
          chk("vec_dp", 32'(dp), 32'(v.dpo[k]));
          lit_cnt++;
        end
    end
    chk("vec_lit_cycles", 32'(lit_cnt), 32'(N * (RD - DC)));
  endtask

  initial begin
    int cnt, k;
    tbl[0] = '{16'h1234, 4'h0, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0};
    tbl[1] = '{16'h0050, 4'h0, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'h0};
    tbl[2] = '{16'h0000, 4'h0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0};
    tbl[3] = '{16'h00A0, 4'h4, 1'b1, {7'h00, 7'h00, 7'h40, 7'h3F}, 4'h4};
    tbl[4] = '{16'h8888, 4'h0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'h0};
    tbl[5] = '{16'h0000, 4'h0, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'h0};
    tbl[6] = '{16'h0F07, 4'h0, 1'b1, {7'h00, 7'h40, 7'h3F, 7'h07}, 4'h0};

    reset = 1'b1;
    step(); step();
    chk("rst_anode", 32'(anode), 32'h0);
    chk("rst_seg", 32'(segments), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_anode_n", 32'(an_n), 32'hF);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    reset = 1'b0;
    enable = 1'b1;

    // Basic scan order and frame period.
    run_vec(tbl[0]);
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      do begin step(); cnt++; end while (!frame_done && cnt < 40);
      chk("frame_period", 32'(cnt), 32'(N * RD));
    end

    // Blanking, dash and dp-through-blank.
    for (int t = 1; t <= 3; t++) run_vec(tbl[t]);

    // Active-low instance on an all-eights value.
    run_vec(tbl[4]);
    cnt = 0;
    while (an_n == 4'hF && cnt < 8) begin step(); cnt++; end
    chk("n_seg_lit", 32'(seg_n), 32'h00);
    chk("n_anode_onehot", 32'($countones(~an_n)), 32'd1);
    cnt = 0;
    while (an_n != 4'hF && cnt < 8) begin step(); cnt++; end
    chk("n_dead_seg", 32'(seg_n), 32'h7F);
    chk("n_dead_dp", 32'(dp_n), 32'h1);

    // Mid-frame load is deferred; a boundary-coincident load wins over pending.
    run_vec(tbl[0]);
    for (int i = 0; i < 5; i++) step();
    value_in = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 40 && !(m_idx == N - 1 && m_presc == RD - 1); i++) begin
      step();
      for (int j = 0; j < N; j++)
        if (anode == 4'(1 << j)) chk("no_tear_seg", 32'(segments), 32'(tbl[0].seg[j]));
    end
    value_in = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    chk("boundary_fd", 32'(frame_done), 32'd1);
    cnt = 0;
    for (int i = 0; i < 4 * RD; i++) begin
      step();
      if (anode != 4'h0) begin
        chk("boundary_load_seg", 32'(segments), 32'h06);
        cnt++;
      end
    end
    chk("boundary_lit_cycles", 32'(cnt), 32'(N * (RD - DC)));

    // Enable dropped mid-slot, then resumed.
    for (int i = 0; i < 8 && m_presc != 2; i++) step();
    k = m_idx;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("dis_anode", 32'(anode), 32'h0);
      chk("dis_fd", 32'(frame_done), 32'h0);
    end
    enable = 1'b1;
    step();
    chk("resume_anode", 32'(anode), 32'(1 << k));
    step();
    chk("resume_anode2", 32'(anode), 32'(1 << k));
    step();
    chk("resume_dead", 32'(anode), 32'h0);
    step();
    chk("resume_next", 32'(anode), 32'(1 << ((k + 1) % N)));

    // Reset mid-frame: outputs go inactive, scan restarts at digit 0, pending lost.
    step();
    reset = 1'b1;
    step();
    chk("midrst_anode", 32'(anode), 32'h0);
    chk("midrst_seg", 32'(segments), 32'h0);
    chk("midrst_fd", 32'(frame_done), 32'h0);
    chk("midrst_anode_n", 32'(an_n), 32'hF);
    reset = 1'b0;
    step();
    chk("restart_dead", 32'(anode), 32'h0);
    step();
    chk("restart_anode", 32'(anode), 32'h1);
    chk("restart_seg", 32'(segments), 32'h3F);

    run_vec(tbl[5]);
    run_vec(tbl[6]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
